reg_responder: RTL and testbench



---
 rtl/reg_responder.sv | 112 +++++++++++
 tb/tb_reg_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_responder.sv
// rtl/reg_responder.sv - register-bank request/response target with fixed-latency in-order responses
// Requests are throttled by an outstanding count so the response FIFO never overflows.
module reg_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_REGS    = 16,
  parameter int RSP_LATENCY = 2,
  parameter int RSP_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [ADDR_WIDTH:0] NUM_REGS_A = (ADDR_WIDTH+1)'(NUM_REGS);
  localparam logic [CNT_W-1:0]    DEPTH_C    = CNT_W'(RSP_DEPTH);
  localparam logic [PTR_W-1:0]    LAST_PTR   = PTR_W'(RSP_DEPTH - 1);

  logic [DATA_WIDTH-1:0]  regs_q [NUM_REGS];

  logic [RSP_LATENCY-1:0] pv_q, pw_q, pe_q;
  logic [DATA_WIDTH-1:0]  pd_q [RSP_LATENCY];

  logic [RSP_DEPTH-1:0]   fw_q, fe_q;
  logic [DATA_WIDTH-1:0]  fd_q [RSP_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, out_q, out_d;

  logic                   accept, in_range, push, pop;
  logic [IDX_W-1:0]       idx;
  logic [DATA_WIDTH-1:0]  stage0_data;

  assign req_ready   = rst_n && (out_q < DEPTH_C);
  assign accept      = req_valid && req_ready;
  assign in_range    = ({1'b0, req_addr} < NUM_REGS_A);
  assign idx         = req_addr[IDX_W-1:0];
  // Read data is sampled before the accept edge, so a same-edge write cannot leak in.
  assign stage0_data = (!req_write && in_range) ? regs_q[idx] : '0;

  assign push      = pv_q[RSP_LATENCY-1];
  assign rsp_valid = (cnt_q != '0);
  assign pop       = rsp_valid && rsp_ready;

  assign rsp_write = rsp_valid && fw_q[rd_ptr_q];
  assign rsp_error = rsp_valid && fe_q[rd_ptr_q];
  assign rsp_rdata = rsp_valid ? fd_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;
    if (accept && !pop)      out_d = out_q + 1'b1;
    else if (!accept && pop) out_d = out_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      pv_q <= '0;
      pw_q <= '0;
      pe_q <= '0;
      for (int i = 0; i < RSP_LATENCY; i++) pd_q[i] <= '0;
      fw_q <= '0;
      fe_q <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) fd_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
    end else begin
      if (accept && in_range && req_write) regs_q[idx] <= req_wdata;
      pv_q[0] <= accept;
      pw_q[0] <= req_write;
      pe_q[0] <= !in_range;
      pd_q[0] <= stage0_data;
      for (int i = 1; i < RSP_LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pw_q[i] <= pw_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
      // The outstanding limit guarantees a free slot whenever push is high.
      if (push) begin
        fw_q[wr_ptr_q] <= pw_q[RSP_LATENCY-1];
        fe_q[wr_ptr_q] <= pe_q[RSP_LATENCY-1];
        fd_q[wr_ptr_q] <= pd_q[RSP_LATENCY-1];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
    end
  end

endmodule

// File: tb/tb_reg_responder.sv
// tb/tb_reg_responder.sv - self-checking bench for reg_responder
// Directed vector table, hand-written corner sequences and a queue-based reference model.
module tb_reg_responder;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NR = 16;
  localparam int LAT = 2;
  localparam int DEP = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;

  reg_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR),
                  .RSP_LATENCY(LAT), .RSP_DEPTH(DEP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: timestamped in-flight queue feeding an ordered response queue.
  typedef struct {
    logic        w;
    logic [31:0] d;
    logic        e;
    int          due;
  } rsp_t;

  rsp_t        pipe_q[$];
  rsp_t        fifo_q[$];
  logic [31:0] mregs[NR];
  int          m_out;
  int          m_edge;
  int          m_acc;

  task automatic model_reset();
    pipe_q.delete();
    fifo_q.delete();
    for (int i = 0; i < NR; i++) mregs[i] = '0;
    m_out = 0;
  endtask

  task automatic model_check(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'(m_out < DEP));
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(fifo_q.size() > 0));
    if (fifo_q.size() > 0 && rsp_valid) begin
      chk({tag, "_rsp_write"}, 32'(rsp_write), 32'(fifo_q[0].w));
      chk({tag, "_rsp_rdata"}, rsp_rdata, fifo_q[0].d);
      chk({tag, "_rsp_error"}, 32'(rsp_error), 32'(fifo_q[0].e));
    end
  endtask

  task automatic model_edge();
    rsp_t r;
    bit acc, pop;
    acc = req_valid && (m_out < DEP);
    pop = rsp_ready && (fifo_q.size() > 0);
    if (pop) void'(fifo_q.pop_front());
    if (acc) begin
      r.w   = req_write;
      r.e   = (req_addr >= NR);
      r.d   = (!req_write && !r.e) ? mregs[req_addr[3:0]] : 32'h0;
      r.due = m_edge + LAT;
      if (req_write && !r.e) mregs[req_addr[3:0]] = req_wdata;
      pipe_q.push_back(r);
      m_acc++;
    end
    m_out += int'(acc) - int'(pop);
    while (pipe_q.size() > 0 && pipe_q[0].due == m_edge) fifo_q.push_back(pipe_q.pop_front());
  endtask

  // Cycle protocol: inputs driven at posedge+1, outputs checked at negedge.
  task automatic cyc_begin(input logic v, input logic w, input logic [7:0] a,
                           input logic [31:0] d, input logic rr);
    req_valid = v; req_write = w; req_addr = a; req_wdata = d; rsp_ready = rr;
    #4;
  endtask

  task automatic cyc_end();
    model_edge();
    @(posedge clk);
    m_edge++;
    #1;
  endtask

  task automatic cyc(input logic v, input logic w, input logic [7:0] a,
                     input logic [31:0] d, input logic rr, input string tag);
    cyc_begin(v, w, a, d, rr);
    model_check(tag);
    cyc_end();
  endtask

  typedef struct {
    logic        v, w;
    logic [7:0]  a;
    logic [31:0] d;
    logic        rr;
    logic        e_ready, e_valid, e_write;
    logic [31:0] e_rdata;
    logic        e_error;
  } vec_t;

  vec_t vt[8];

  int accepted, seen, guard;

  initial begin
    vt[0] = '{1, 1, 8'd3,  32'hDEADBEEF, 1, 1, 0, 0, 32'h0,        0};
    vt[1] = '{1, 0, 8'd3,  32'h0,        1, 1, 0, 0, 32'h0,        0};
    vt[2] = '{1, 0, 8'd20, 32'h0,        1, 1, 0, 0, 32'h0,        0};
    vt[3] = '{1, 0, 8'd15, 32'h0,        1, 1, 1, 1, 32'h0,        0};
    vt[4] = '{0, 0, 8'd0,  32'h0,        1, 1, 1, 0, 32'hDEADBEEF, 0};
    vt[5] = '{0, 0, 8'd0,  32'h0,        1, 1, 1, 0, 32'h0,        1};
    vt[6] = '{0, 0, 8'd0,  32'h0,        1, 1, 1, 0, 32'h0,        0};
    vt[7] = '{0, 0, 8'd0,  32'h0,        1, 1, 0, 0, 32'h0,        0};

    m_edge = 0;
    m_acc  = 0;
    model_reset();

    // Reset state
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_write", 32'(rsp_write), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_error", 32'(rsp_error), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    m_edge++;
    #1;

    // Tests 1/2: directed vector table
    for (int i = 0; i < 8; i++) begin
      cyc_begin(vt[i].v, vt[i].w, vt[i].a, vt[i].d, vt[i].rr);
      chk($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(vt[i].e_ready));
      chk($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'(vt[i].e_valid));
      if (vt[i].e_valid) begin
        chk($sformatf("vec%0d_rsp_write", i), 32'(rsp_write), 32'(vt[i].e_write));
        chk($sformatf("vec%0d_rsp_rdata", i), rsp_rdata, vt[i].e_rdata);
        chk($sformatf("vec%0d_rsp_error", i), 32'(rsp_error), 32'(vt[i].e_error));
      end
      cyc_end();
    end

    // Test 3: fill to RSP_DEPTH with rsp_ready low, then free one slot
    accepted = 0;
    for (int i = 0; i < 8; i++) begin
      cyc_begin(1, 1, 8'(i), 32'h100 + i, 0);
      if (req_ready) accepted++;
      model_check("t3_fill");
      cyc_end();
    end
    chk("t3_accepted", accepted, 4);
    cyc_begin(0, 0, 8'd0, 32'h0, 1);
    model_check("t3_pulse");
    cyc_end();
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      cyc_begin(1, 0, 8'(i), 32'h0, 0);
      if (req_ready) accepted++;
      model_check("t3_refill");
      cyc_end();
    end
    chk("t3_one_more", accepted, 1);
    chk("t3_ready_low", 32'(req_ready), 32'h0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 8'd0, 32'h0, 1, "t3_drain");

    // Test 4: streaming writes then reads at full rate
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 8)       cyc_begin(1, 1, 8'(i), $urandom, 1);
      else if (i < 16) cyc_begin(1, 0, 8'(i - 8), 32'h0, 1);
      else             cyc_begin(0, 0, 8'd0, 32'h0, 1);
      if (i < 16) chk("t4_ready_high", 32'(req_ready), 32'h1);
      if (rsp_valid) seen++;
      model_check("t4");
      cyc_end();
    end
    chk("t4_rsp_count", seen, 16);

    // Test 5: random traffic with random back-pressure
    accepted = m_acc;
    seen = 0;
    guard = 0;
    while (m_acc - accepted < 1000 && guard < 20000) begin
      cyc_begin($urandom_range(0, 3) != 0, $urandom_range(0, 1), 8'($urandom_range(0, 19)),
                $urandom, $urandom_range(0, 2) != 0);
      if (rsp_valid && rsp_ready) seen++;
      model_check("t5");
      cyc_end();
      guard++;
    end
    chk("t5_budget", 32'(guard < 20000), 32'h1);
    guard = 0;
    while ((m_out > 0) && guard < 50) begin
      cyc_begin(0, 0, 8'd0, 32'h0, 1);
      if (rsp_valid && rsp_ready) seen++;
      model_check("t5_drain");
      cyc_end();
      guard++;
    end
    chk("t5_rsp_count", seen, m_acc - accepted);

    // Test 6: reset mid-stream with three transactions outstanding
    for (int i = 1; i <= 3; i++) cyc(1, 1, 8'(i), 32'hA0 + i, 0, "t6_load");
    for (int i = 0; i < 3; i++) cyc(0, 0, 8'd0, 32'h0, 0, "t6_wait");
    req_valid = 1'b0;
    #4;
    chk("t6_pre_valid", 32'(rsp_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(rsp_valid), 32'h0);
    chk("t6_rst_ready", 32'(req_ready), 32'h0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    m_edge += 3;
    #1;
    for (int i = 1; i <= 3; i++) cyc(1, 0, 8'(i), 32'h0, 1, "t6_read");
    for (int i = 0; i < 6; i++) cyc(0, 0, 8'd0, 32'h0, 1, "t6_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
